// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings and flag bit positions.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_SAR = 4'd10;
  localparam logic [3:0] OP_ROL = 4'd11;
  localparam logic [3:0] OP_ROR = 4'd12;

  // Flag vector is packed as {S, Z, C, P, O}
  localparam int NFLAGS = 5;
  localparam int FLAG_O = 0;
  localparam int FLAG_P = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_S = 4;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational datapath: computes the result and next flags from op, operands and carry-in.
import alu_pkg::*;

module alu_pipe_core #(
  parameter int W  = 16,
  parameter int SH = $clog2(W)
) (
  input  logic [3:0]        op,
  input  logic [W-1:0]      x,
  input  logic [W-1:0]      y,
  input  logic              cin,
  output logic [W-1:0]      r,
  output logic [NFLAGS-1:0] flags
);

  function automatic logic even_parity(input logic [W-1:0] v);
    return ~(^v);
  endfunction

  logic [SH-1:0] k_s;
  logic [SH-1:0] shl_idx_s;
  logic [SH-1:0] shr_idx_s;
  logic [SH:0]   k_inv_s;
  logic          add_cin_s;
  logic          sub_cin_s;
  logic [W:0]    add_s;
  logic [W:0]    sub_s;
  logic          add_ovf_s;
  logic          sub_ovf_s;
  logic [W-1:0]  r_s;
  logic          c_s;
  logic          o_s;

  assign k_s       = y[SH-1:0];
  // Carry-out bit positions for shifts; only meaningful when k != 0
  assign shl_idx_s = SH'(W) - k_s;
  assign shr_idx_s = k_s - SH'(1);
  assign k_inv_s   = (SH+1)'(W) - {1'b0, k_s};

  assign add_cin_s = (op == OP_ADC) ? cin : 1'b0;
  assign sub_cin_s = (op == OP_SBB) ? cin : 1'b0;
  assign add_s     = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, add_cin_s};
  assign sub_s     = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, sub_cin_s};
  assign add_ovf_s = (x[W-1] == y[W-1]) && (add_s[W-1] != x[W-1]);
  assign sub_ovf_s = (x[W-1] != y[W-1]) && (sub_s[W-1] != x[W-1]);

  // Opcode decode; reserved opcodes and zero-distance shifts pass x through with carry held
  always_comb begin
    r_s = x;
    c_s = cin;
    o_s = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        r_s = add_s[W-1:0];
        c_s = add_s[W];
        o_s = add_ovf_s;
      end
      OP_SUB, OP_SBB: begin
        r_s = sub_s[W-1:0];
        c_s = sub_s[W];
        o_s = sub_ovf_s;
      end
      OP_AND: begin r_s = x & y; c_s = 1'b0; end
      OP_OR:  begin r_s = x | y; c_s = 1'b0; end
      OP_XOR: begin r_s = x ^ y; c_s = 1'b0; end
      OP_NOT: begin r_s = ~x;    c_s = 1'b0; end
      OP_SHL: begin
        if (k_s != {SH{1'b0}}) begin
          r_s = x << k_s;
          c_s = x[shl_idx_s];
        end else begin
          r_s = x;
        end
      end
      OP_SHR: begin
        if (k_s != {SH{1'b0}}) begin
          r_s = x >> k_s;
          c_s = x[shr_idx_s];
        end else begin
          r_s = x;
        end
      end
      OP_SAR: begin
        if (k_s != {SH{1'b0}}) begin
          r_s = $signed(x) >>> k_s;
          c_s = x[shr_idx_s];
        end else begin
          r_s = x;
        end
      end
      OP_ROL: begin
        if (k_s != {SH{1'b0}}) begin
          r_s = (x << k_s) | (x >> k_inv_s);
          c_s = r_s[0];
        end else begin
          r_s = x;
        end
      end
      OP_ROR: begin
        if (k_s != {SH{1'b0}}) begin
          r_s = (x >> k_s) | (x << k_inv_s);
          c_s = r_s[W-1];
        end else begin
          r_s = x;
        end
      end
      default: begin
        r_s = x;
        c_s = cin;
        o_s = 1'b0;
      end
    endcase
  end

  assign r              = r_s;
  assign flags[FLAG_S]  = r_s[W-1];
  assign flags[FLAG_Z]  = (r_s == {W{1'b0}});
  assign flags[FLAG_C]  = c_s;
  assign flags[FLAG_P]  = even_parity(r_s);
  assign flags[FLAG_O]  = o_s;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU stage with valid/ready on both sides; the flag register is the architectural carry.
import alu_pkg::*;

module alu_pipe #(
  parameter int W  = 16,
  parameter int SH = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic         sign,
  output logic         zero,
  output logic         carry,
  output logic         parity,
  output logic         overflow
);

  logic [W-1:0]      r_s;
  logic [NFLAGS-1:0] flags_s;
  logic [W-1:0]      z_r;
  logic [NFLAGS-1:0] flags_r;
  logic              out_valid_r;
  logic              issue_s;
  logic              accept_s;

  assign in_ready = !out_valid_r || out_ready;
  assign issue_s  = in_valid && in_ready;
  assign accept_s = out_valid_r && out_ready;

  alu_pipe_core #(.W(W), .SH(SH)) u_core (
    .op    (op),
    .x     (x),
    .y     (y),
    .cin   (flags_r[FLAG_C]),
    .r     (r_s),
    .flags (flags_s)
  );

  // Result register: load on issue, drop valid on a pure accept, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_r         <= {W{1'b0}};
      flags_r     <= {NFLAGS{1'b0}};
      out_valid_r <= 1'b0;
    end else if (issue_s) begin
      z_r         <= r_s;
      flags_r     <= flags_s;
      out_valid_r <= 1'b1;
    end else if (accept_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign z         = z_r;
  assign sign      = flags_r[FLAG_S];
  assign zero      = flags_r[FLAG_Z];
  assign carry     = flags_r[FLAG_C];
  assign parity    = flags_r[FLAG_P];
  assign overflow  = flags_r[FLAG_O];

endmodule
